bus_sequencer: RTL and testbench

BUS_SEQUENCER -- requirements
Module: bus_sequencer

---
 rtl/bus_sequencer.sv | 152 +++++++++++++++
 tb/tb_bus_sequencer.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_sequencer.sv
// Microsequencer: runs a 16-word ROM program, driving a shared 4-bit bus with one-cycle load strobes.
// Two cycles per instruction (FETCH, EXEC); each run is bounded by a watchdog on executed instructions.
module bus_sequencer #(
    parameter int WDOG_MAX = 255
) (
    input  logic       CK,
    input  logic       RST_N,
    input  logic       START,
    input  logic [7:0] INSTR,
    input  logic [3:0] A_IN,
    input  logic [3:0] B_IN,
    output logic [3:0] PC,
    output logic [3:0] BUS,
    output logic       LD_A,
    output logic       LD_B,
    output logic       LD_out,
    output logic       BUSY,
    output logic       DONE,
    output logic       ERR
);

    localparam int WW = (WDOG_MAX < 2) ? 1 : $clog2(WDOG_MAX + 1);

    localparam logic [3:0] OP_LDA  = 4'h1;
    localparam logic [3:0] OP_LDB  = 4'h2;
    localparam logic [3:0] OP_MAB  = 4'h3;
    localparam logic [3:0] OP_MBA  = 4'h4;
    localparam logic [3:0] OP_OUTA = 4'h5;
    localparam logic [3:0] OP_OUTB = 4'h6;
    localparam logic [3:0] OP_OUTI = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_JZA  = 4'h9;
    localparam logic [3:0] OP_DECA = 4'hA;
    localparam logic [3:0] OP_INCB = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_EXEC,
        S_HALTED
    } state_t;

    state_t        state_q;
    logic [3:0]    pc_q;
    logic [7:0]    ir_q;
    logic [WW-1:0] wdog_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;

    logic [3:0]    opc;
    logic [3:0]    imm;
    logic [3:0]    bus_w;
    logic          ld_a_w;
    logic          ld_b_w;
    logic          ld_out_w;
    logic [3:0]    pc_next;
    logic [WW-1:0] wdog_inc;
    logic          wdog_hit;

    assign opc      = ir_q[7:4];
    assign imm      = ir_q[3:0];
    assign wdog_inc = wdog_q + WW'(1);
    assign wdog_hit = (wdog_inc >= WW'(WDOG_MAX));

    // Strobes are decoded straight from IR and gated by state, so an async reset kills them at once.
    always_comb begin
        bus_w    = 4'h0;
        ld_a_w   = 1'b0;
        ld_b_w   = 1'b0;
        ld_out_w = 1'b0;
        pc_next  = pc_q + 4'd1;
        case (opc)
            OP_LDA:  begin bus_w = imm;         ld_a_w   = 1'b1; end
            OP_LDB:  begin bus_w = imm;         ld_b_w   = 1'b1; end
            OP_MAB:  begin bus_w = A_IN;        ld_b_w   = 1'b1; end
            OP_MBA:  begin bus_w = B_IN;        ld_a_w   = 1'b1; end
            OP_OUTA: begin bus_w = A_IN;        ld_out_w = 1'b1; end
            OP_OUTB: begin bus_w = B_IN;        ld_out_w = 1'b1; end
            OP_OUTI: begin bus_w = imm;         ld_out_w = 1'b1; end
            OP_DECA: begin bus_w = A_IN - 4'd1; ld_a_w   = 1'b1; end
            OP_INCB: begin bus_w = B_IN + 4'd1; ld_b_w   = 1'b1; end
            OP_JMP:  pc_next = imm;
            OP_JZA:  if (A_IN == 4'h0) pc_next = imm;
            default: ;
        endcase
        if (state_q != S_EXEC) begin
            bus_w    = 4'h0;
            ld_a_w   = 1'b0;
            ld_b_w   = 1'b0;
            ld_out_w = 1'b0;
        end
    end

    always_ff @(posedge CK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= S_IDLE;
            pc_q    <= 4'h0;
            ir_q    <= 8'h00;
            wdog_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_HALTED: begin
                    if (START) begin
                        state_q <= S_FETCH;
                        pc_q    <= 4'h0;
                        wdog_q  <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        err_q   <= 1'b0;
                    end
                end
                S_FETCH: begin
                    ir_q    <= INSTR;
                    state_q <= S_EXEC;
                end
                S_EXEC: begin
                    wdog_q <= wdog_inc;
                    // HALT wins over a coinciding watchdog expiry; both leave PC where it stopped.
                    if (opc == OP_HALT) begin
                        state_q <= S_HALTED;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else if (wdog_hit) begin
                        state_q <= S_HALTED;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                    end else begin
                        pc_q    <= pc_next;
                        state_q <= S_FETCH;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign PC     = pc_q;
    assign BUS    = bus_w;
    assign LD_A   = ld_a_w;
    assign LD_B   = ld_b_w;
    assign LD_out = ld_out_w;
    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERR    = err_q;

endmodule

// File: tb/tb_bus_sequencer.sv
// Directed bench for bus_sequencer: ROM and A/B/out registers modelled around the DUT.
module tb_bus_sequencer;

    logic       CK = 1'b0;
    logic       RST_N;
    logic       START;
    logic [7:0] INSTR;
    logic [3:0] A_IN, B_IN, PC, BUS;
    logic       LD_A, LD_B, LD_out, BUSY, DONE, ERR;

    int checks   = 0;
    int failures = 0;

    logic [7:0] rom [16];
    logic [3:0] a_reg, b_reg, out_reg;
    logic       ovr_en = 1'b0;
    logic [3:0] ovr_a  = 4'h0;
    logic [3:0] ovr_b  = 4'h0;

    always #5 CK = ~CK;

    assign INSTR = rom[PC];
    assign A_IN  = ovr_en ? ovr_a : a_reg;
    assign B_IN  = ovr_en ? ovr_b : b_reg;

    always @(posedge CK) begin
        if (LD_A)   a_reg   <= BUS;
        if (LD_B)   b_reg   <= BUS;
        if (LD_out) out_reg <= BUS;
    end

    bus_sequencer #(.WDOG_MAX(10)) dut (
        .CK(CK), .RST_N(RST_N), .START(START), .INSTR(INSTR),
        .A_IN(A_IN), .B_IN(B_IN), .PC(PC), .BUS(BUS),
        .LD_A(LD_A), .LD_B(LD_B), .LD_out(LD_out),
        .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    task automatic rom_clear();
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
    endtask

    task automatic start_run();
        START = 1'b1;
        @(negedge CK);
        START = 1'b0;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        START = 1'b0;
        rom_clear();
        #3;
        checks++;
        if ({PC, BUS, LD_A, LD_B, LD_out, BUSY, DONE, ERR} !== 14'h0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {PC, BUS, LD_A, LD_B, LD_out, BUSY, DONE, ERR});
        end
        repeat (2) @(negedge CK);
        RST_N = 1'b1;
        repeat (3) @(negedge CK);
        checks++;
        if ({PC, BUSY, DONE, ERR} !== 7'h0) begin
            failures++;
            $display("FAIL idle_no_start got=%h exp=0", {PC, BUSY, DONE, ERR});
        end
    endtask

    task automatic test_basic();
        rom_clear();
        rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h50; rom[3] = 8'hF0;
        start_run();
        checks++;
        if ({BUSY, PC} !== 5'b1_0000) begin
            failures++; $display("FAIL basic_fetch0 got=%b exp=10000", {BUSY, PC});
        end
        @(negedge CK);
        checks++;
        if ({LD_A, LD_B, LD_out, BUS} !== 7'b100_0011) begin
            failures++; $display("FAIL basic_lda got=%b exp=1000011", {LD_A, LD_B, LD_out, BUS});
        end
        repeat (2) @(negedge CK);
        checks++;
        if ({LD_A, LD_B, LD_out, BUS} !== 7'b010_0101) begin
            failures++; $display("FAIL basic_ldb got=%b exp=0100101", {LD_A, LD_B, LD_out, BUS});
        end
        repeat (2) @(negedge CK);
        checks++;
        if ({LD_A, LD_B, LD_out, BUS} !== 7'b001_0011) begin
            failures++; $display("FAIL basic_outa got=%b exp=0010011", {LD_A, LD_B, LD_out, BUS});
        end
        repeat (2) @(negedge CK);
        checks++;
        if ({LD_A, LD_B, LD_out, BUS, DONE} !== 8'h00) begin
            failures++; $display("FAIL basic_halt_exec got=%b exp=0", {LD_A, LD_B, LD_out, BUS, DONE});
        end
        @(negedge CK);
        checks++;
        if ({BUSY, DONE, ERR, PC} !== 7'b010_0011) begin
            failures++; $display("FAIL basic_done got=%b exp=0100011", {BUSY, DONE, ERR, PC});
        end
        checks++;
        if (out_reg !== 4'h3) begin
            failures++; $display("FAIL basic_out_reg got=%h exp=3", out_reg);
        end
    endtask

    // Countdown loop: JZA falls through once at A=1, then is taken at A=0 onto the HALT.
    task automatic test_jza();
        int          k;
        logic [27:0] pcs;
        logic [11:0] lds;
        rom_clear();
        rom[0] = 8'h12; rom[1] = 8'hA0; rom[2] = 8'h94; rom[3] = 8'h81; rom[4] = 8'hF0;
        k = 0; pcs = '0; lds = '0;
        start_run();
        while (!DONE && k < 40) begin
            if (k % 2 == 0) pcs = {pcs[23:0], PC};
            if (LD_A) lds = {lds[7:0], BUS};
            @(negedge CK);
            k++;
        end
        checks++;
        if (k !== 14) begin
            failures++; $display("FAIL jza_cycles got=%0d exp=14", k);
        end
        checks++;
        if (pcs !== 28'h0123124) begin
            failures++; $display("FAIL jza_fetch_pcs got=%h exp=0123124", pcs);
        end
        checks++;
        if (lds !== 12'h210) begin
            failures++; $display("FAIL jza_lda_values got=%h exp=210", lds);
        end
        checks++;
        if ({DONE, ERR, PC} !== 6'b10_0100) begin
            failures++; $display("FAIL jza_done got=%b exp=100100", {DONE, ERR, PC});
        end
    endtask

    task automatic test_decode_wrap();
        logic [6:0] exp_t [9];
        exp_t = '{7'b010_0000, 7'b100_1111, 7'b001_1111, 7'b100_1111, 7'b010_0000,
                  7'b001_1100, 7'b000_0000, 7'b000_0000, 7'b000_0000};
        rom_clear();
        rom[0] = 8'h30; rom[1] = 8'h40; rom[2] = 8'h60; rom[3] = 8'hA0; rom[4] = 8'hB0;
        rom[5] = 8'h7C; rom[6] = 8'hC5; rom[7] = 8'h8A; rom[10] = 8'hF0;
        ovr_en = 1'b1; ovr_a = 4'h0; ovr_b = 4'hF;
        start_run();
        for (int i = 0; i < 9; i++) begin
            @(negedge CK);
            checks++;
            if ({LD_A, LD_B, LD_out, BUS} !== exp_t[i]) begin
                failures++;
                $display("FAIL decode_exec%0d got=%b exp=%b", i, {LD_A, LD_B, LD_out, BUS}, exp_t[i]);
            end
            @(negedge CK);
        end
        checks++;
        if ({DONE, ERR, PC} !== 6'b10_1010) begin
            failures++; $display("FAIL decode_done got=%b exp=101010", {DONE, ERR, PC});
        end
        ovr_en = 1'b0;
    endtask

    task automatic test_watchdog();
        int k;
        rom_clear();
        rom[0] = 8'h80;
        k = 0;
        start_run();
        while (!DONE && k < 60) begin
            @(negedge CK);
            k++;
        end
        checks++;
        if (k !== 20) begin
            failures++; $display("FAIL wdog_cycles got=%0d exp=20", k);
        end
        checks++;
        if ({DONE, ERR, BUSY} !== 3'b110) begin
            failures++; $display("FAIL wdog_flags got=%b exp=110", {DONE, ERR, BUSY});
        end
    endtask

    task automatic test_halt_vs_wdog();
        int k;
        rom_clear();
        rom[9] = 8'hF0;
        k = 0;
        start_run();
        checks++;
        if ({ERR, DONE, BUSY} !== 3'b001) begin
            failures++; $display("FAIL err_cleared got=%b exp=001", {ERR, DONE, BUSY});
        end
        while (!DONE && k < 60) begin
            @(negedge CK);
            k++;
        end
        checks++;
        if (k !== 20) begin
            failures++; $display("FAIL halt_wdog_cycles got=%0d exp=20", k);
        end
        checks++;
        if ({DONE, ERR, PC} !== 6'b10_1001) begin
            failures++; $display("FAIL halt_wdog_flags got=%b exp=101001", {DONE, ERR, PC});
        end
    endtask

    task automatic test_reset_mid_exec();
        rom_clear();
        rom[0] = 8'h13; rom[1] = 8'hF0;
        start_run();
        @(negedge CK);
        checks++;
        if (LD_A !== 1'b1) begin
            failures++; $display("FAIL rst_pre_lda got=%b exp=1", LD_A);
        end
        #1 RST_N = 1'b0;
        #1;
        checks++;
        if ({PC, BUS, LD_A, LD_B, LD_out, BUSY, DONE, ERR} !== 14'h0) begin
            failures++;
            $display("FAIL rst_mid_exec got=%h exp=0", {PC, BUS, LD_A, LD_B, LD_out, BUSY, DONE, ERR});
        end
        @(negedge CK);
        RST_N = 1'b1;
        @(negedge CK);
        start_run();
        checks++;
        if ({BUSY, PC} !== 5'b1_0000) begin
            failures++; $display("FAIL rst_restart got=%b exp=10000", {BUSY, PC});
        end
        @(negedge CK);
        checks++;
        if ({LD_A, LD_B, LD_out, BUS} !== 7'b100_0011) begin
            failures++; $display("FAIL rst_restart_lda got=%b exp=1000011", {LD_A, LD_B, LD_out, BUS});
        end
        repeat (3) @(negedge CK);
        checks++;
        if ({DONE, ERR, PC} !== 6'b10_0001) begin
            failures++; $display("FAIL rst_restart_done got=%b exp=100001", {DONE, ERR, PC});
        end
    endtask

    task automatic test_start_held();
        rom_clear();
        rom[0] = 8'h13; rom[1] = 8'hF0;
        START = 1'b1;
        @(negedge CK);
        checks++;
        if ({BUSY, DONE, ERR, PC} !== 7'b100_0000) begin
            failures++; $display("FAIL held_fetch0 got=%b exp=1000000", {BUSY, DONE, ERR, PC});
        end
        repeat (2) @(negedge CK);
        checks++;
        if ({BUSY, PC} !== 5'b1_0001) begin
            failures++; $display("FAIL held_no_restart got=%b exp=10001", {BUSY, PC});
        end
        repeat (2) @(negedge CK);
        checks++;
        if ({BUSY, DONE, PC} !== 6'b01_0001) begin
            failures++; $display("FAIL held_done got=%b exp=010001", {BUSY, DONE, PC});
        end
        @(negedge CK);
        checks++;
        if ({BUSY, DONE, PC} !== 6'b10_0000) begin
            failures++; $display("FAIL held_restart got=%b exp=100000", {BUSY, DONE, PC});
        end
        START = 1'b0;
        repeat (4) @(negedge CK);
        checks++;
        if ({DONE, ERR, PC} !== 6'b10_0001) begin
            failures++; $display("FAIL held_final got=%b exp=100001", {DONE, ERR, PC});
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_jza();
        test_decode_wrap();
        test_watchdog();
        test_halt_vs_wdog();
        test_reset_mid_exec();
        test_start_held();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
